step_dir_decoder: RTL and testbench
===================================

# step_dir_decoder

Receive-side counterpart to the stepper step-clock generator. Accepts an asynchronous STEP/DIR pair (from the divider-driven step generator or an external driver), synchronizes it to clk, and tracks signed motor position. Also measures the step period in clk cycles and flags a stall when no step arrives within a timeout. Sits between the stepper I/O pins and the motion-control logic as position/speed feedback.

## Interface
- POS_W, 32: width of signed position counter
- PER_W, 32: width of period measurement
- TIMEOUT, 100000000: cycles without a step before stall is flagged (≥2, < 2^PER_W)
- clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- step_in  in  1  asynchronous step input, rising edge = one step
- dir_in  in  1  asynchronous direction; 1 = forward (+1), 0 = reverse (−1)
- clear  in  1  synchronous clear of position, period logic and stall flag
- pos_out  out  POS_W  signed position, two's complement
- step_pulse  out  1  one-cycle strobe per accepted step
- period_out  out  PER_W  cycles between the last two accepted steps
- period_valid  out  1  one-cycle strobe when period_out updates
- stalled  out  1  high while no step seen for TIMEOUT cycles

## Operation
- step_in, dir_in each pass through a 2-flop synchronizer, then a third register for step edge detection; edge = s2 & ~s3.
- On edge: pos_out ± 1 per synchronized dir sampled in the same cycle; step_pulse = 1 for one cycle.
- Position wraps modulo 2^POS_W (0x7FFFFFFF + 1 → 0x80000000; 0 − 1 → 0xFFFFFFFF); no saturation.
- State machine, two states:
  - IDLE: no reference edge. Edge → MEASURE, period counter = 1, no period_valid.
  - MEASURE: counter increments each cycle. Edge → period_out = counter, period_valid pulse, counter = 1, stay. Counter reaching TIMEOUT with no edge → stalled = 1, go IDLE.
- period_out = distance between consecutive step_pulse cycles (pulses at cycles 10 and 110 → 100); holds last value across stall and clear.
- stalled clears on the next accepted edge (same cycle as step_pulse).
- clear: pos_out = 0, state IDLE, counter = 0, stalled = 0; period_out unchanged. Edge coinciding with clear is dropped (no step_pulse, no position change).
- Glitch shorter than one clk period may be missed; no debouncing is performed.

## Timing
- Reset values: pos_out 0, step_pulse 0, period_out 0, period_valid 0, stalled 0, state IDLE, synchronizer flops 0.
- step_in high sampled at clk edge k → step_pulse high and pos_out updated in the cycle following clk edge k+2 (3-cycle latency).
- dir_in must be stable ≥3 clk cycles before step_in rises; dir_in changes with step_in both low are free.
- Minimum step spacing: step_in low ≥2 clk cycles and high ≥2 clk cycles; faster input may merge steps.
- period_valid coincides with step_pulse; stalled asserts in the cycle after counter reaches TIMEOUT.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); first edge after reset is treated as an IDLE edge.

## Structure
- Shared stepper package: state enum (IDLE, MEASURE), default TIMEOUT constant, POS_W/PER_W defaults used by the step generator and this block.
- One sub-module natural: sync_2ff (parameterized-width 2-flop synchronizer), reusable for other pin inputs; instantiated once, width 2.

## Test plan
- Reset, then 5 step pulses with dir_in = 1, spaced 100 cycles → pos_out = 5, 5 step_pulse strobes, 4 period_valid strobes each with period_out = 100.
- 3 forward then 5 reverse steps → pos_out = −2 (0xFFFFFFFE); each step_pulse 3 cycles after step_in rise.
- Preload to 0x7FFFFFFF via 2^31−1 steps (or force), one forward step → pos_out = 0x80000000; from 0 one reverse → 0xFFFFFFFF.
- TIMEOUT = 1000, steps every 200, then none → stalled high after 1000 idle cycles; next step clears stalled, no period_valid; following step gives period_valid with correct spacing.
- clear asserted in the cycle a step edge is detected → pos_out = 0, no step_pulse, state IDLE, period_out retains prior value.
- reset_reset_n pulled low mid-MEASURE with pos_out = 42 → all outputs 0 immediately; first subsequent step → pos_out = 1, no period_valid.

Source files
------------

// File: rtl/step_dir_decoder_pkg.sv
// Shared stepper definitions: measurement state encoding, default widths
// and stall timeout used by both the step generator and the step/dir decoder.
package step_dir_decoder_pkg;

    // Default widths of the signed position counter and period measurement.
    localparam int STEP_POS_W   = 32;
    localparam int STEP_PER_W   = 32;

    // Default number of clk cycles without a step before the motor is
    // considered stalled (one second at 100 MHz).
    localparam int STEP_TIMEOUT = 100_000_000;

    // Period measurement state: IDLE has no reference edge yet, MEASURE is
    // counting cycles since the last accepted step.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

    // Rising-edge detect on a synchronized level and its one-cycle-old copy.
    function automatic logic rise_detect(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/step_dir_decoder_sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous pin inputs.
// Every bit is synchronized independently; no multi-bit coherency is implied.
module sync_2ff #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/step_dir_decoder.sv
// STEP/DIR receiver: synchronizes the step and direction pins, tracks signed
// motor position, measures the step period in clk cycles and flags a stall
// when no step arrives within TIMEOUT cycles.
module step_dir_decoder
    import step_dir_decoder_pkg::*;
#(
    parameter int POS_W   = STEP_POS_W,
    parameter int PER_W   = STEP_PER_W,
    parameter int TIMEOUT = STEP_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_reset_n,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    clear,
    output logic signed [POS_W-1:0] pos_out,
    output logic                    step_pulse,
    output logic [PER_W-1:0]        period_out,
    output logic                    period_valid,
    output logic                    stalled
);

    localparam logic [PER_W-1:0]        TIMEOUT_CNT = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0]        CNT_ONE     = PER_W'(1);
    localparam logic signed [POS_W-1:0] POS_ONE     = POS_W'(1);

    // Position moves by exactly one count and wraps modulo 2^POS_W.
    function automatic logic signed [POS_W-1:0] next_pos(
        input logic signed [POS_W-1:0] cur,
        input logic                    fwd
    );
        return fwd ? (cur + POS_ONE) : (cur - POS_ONE);
    endfunction

    logic [1:0]              sync_q;
    logic                    step_s2;
    logic                    dir_s2;
    logic                    step_s3;
    logic                    step_rise;
    logic                    step_accept;

    logic signed [POS_W-1:0] pos_q;
    logic                    step_pulse_q;
    meas_state_t             state_q;
    logic [PER_W-1:0]        count_q;
    logic [PER_W-1:0]        period_q;
    logic                    period_valid_q;
    logic                    stalled_q;

    sync_2ff #(
        .DATA_W (2)
    ) u_sync (
        .clk           (clk),
        .reset_reset_n (reset_reset_n),
        .d             ({dir_in, step_in}),
        .q             (sync_q)
    );

    assign step_s2 = sync_q[0];
    assign dir_s2  = sync_q[1];

    // Third step register: one-cycle-old copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            step_s3 <= 1'b0;
        end else begin
            step_s3 <= step_s2;
        end
    end

    // A step edge coinciding with clear is discarded rather than deferred.
    assign step_rise   = rise_detect(step_s2, step_s3);
    assign step_accept = step_rise & ~clear;

    // Position counter and step strobe, updated by each accepted edge.
    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pos_q        <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= step_accept;
            if (clear) begin
                pos_q <= '0;
            end else if (step_accept) begin
                pos_q <= next_pos(pos_q, dir_s2);
            end
        end
    end

    // Period measurement / stall FSM; period_out survives clear and stall.
    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (clear) begin
                state_q   <= IDLE;
                count_q   <= '0;
                stalled_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // First edge only establishes the timing reference.
                        if (step_accept) begin
                            state_q   <= MEASURE;
                            count_q   <= CNT_ONE;
                            stalled_q <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // An edge on the timeout cycle still counts as a step.
                        if (step_accept) begin
                            period_q       <= count_q;
                            period_valid_q <= 1'b1;
                            count_q        <= CNT_ONE;
                        end else if (count_q == TIMEOUT_CNT) begin
                            stalled_q <= 1'b1;
                            state_q   <= IDLE;
                            count_q   <= '0;
                        end else begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign pos_out      = pos_q;
    assign step_pulse   = step_pulse_q;
    assign period_out   = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder. A 32-bit instance runs with a short
// stall timeout; a 4-bit instance on the same pins exposes the position
// wrap across the sign bit (7 -> -8) and below zero.
module tb_step_dir_decoder;

    logic        clk;
    logic        reset_reset_n;
    logic        step_in;
    logic        dir_in;
    logic        clear;

    logic [31:0] pos_out;
    logic        step_pulse;
    logic [31:0] period_out;
    logic        period_valid;
    logic        stalled;

    logic [3:0]  pos_small;
    logic        pulse_small;
    logic [31:0] period_small;
    logic        pv_small;
    logic        stalled_small;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_pos;

    step_dir_decoder #(
        .POS_W   (32),
        .PER_W   (32),
        .TIMEOUT (1000)
    ) dut (
        .clk           (clk),
        .reset_reset_n (reset_reset_n),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .clear         (clear),
        .pos_out       (pos_out),
        .step_pulse    (step_pulse),
        .period_out    (period_out),
        .period_valid  (period_valid),
        .stalled       (stalled)
    );

    step_dir_decoder #(
        .POS_W   (4),
        .PER_W   (32),
        .TIMEOUT (1000)
    ) dut_small (
        .clk           (clk),
        .reset_reset_n (reset_reset_n),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .clear         (clear),
        .pos_out       (pos_small),
        .step_pulse    (pulse_small),
        .period_out    (period_small),
        .period_valid  (pv_small),
        .stalled       (stalled_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One step: dir set at negedge A, step rises at A+3, pulse expected at
    // A+6 (third posedge after the rise), step drops at A+6, task ends A+7.
    // Consecutive calls put step_pulse 8+idle cycles apart.
    task automatic do_step(input logic d, input int idle, input bit drop,
                           input logic exp_pv, input logic [31:0] exp_per);
        repeat (idle) @(negedge clk);
        @(negedge clk);
        dir_in = d;
        repeat (3) @(negedge clk);
        step_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_early_pulse", step_pulse, 1'b0);
        if (drop) clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        step_in = 1'b0;
        if (drop)   exp_pos = 32'h0;
        else if (d) exp_pos = exp_pos + 32'h1;
        else        exp_pos = exp_pos - 32'h1;
        chk("step_pulse", step_pulse, !drop);
        chk("pos_out", pos_out, exp_pos);
        chk("pos_small", pos_small, exp_pos[3:0]);
        chk("period_valid", period_valid, exp_pv);
        chk("period_out", period_out, exp_per);
        chk("stalled_at_step", stalled, 1'b0);
        @(negedge clk);
        chk("pulse_one_cycle", step_pulse, 1'b0);
        chk("pv_one_cycle", period_valid, 1'b0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        exp_pos = 32'h0;
        chk("pos_after_clear", pos_out, 32'h0);
        chk("stalled_after_clear", stalled, 1'b0);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        exp_pos       = 32'h0;
        reset_reset_n = 1'b0;
        step_in       = 1'b0;
        dir_in        = 1'b0;
        clear         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pos", pos_out, 32'h0);
        chk("rst_pulse", step_pulse, 1'b0);
        chk("rst_period", period_out, 32'h0);
        chk("rst_pv", period_valid, 1'b0);
        chk("rst_stalled", stalled, 1'b0);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_pos", pos_out, 32'h0);

        // Five forward steps 100 cycles apart
        do_step(1'b1, 5, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) do_step(1'b1, 92, 1'b0, 1'b1, 32'd100);
        chk("pos_five", pos_out, 32'd5);

        // Clear, then 3 forward and 5 reverse -> -2
        pulse_clear();
        chk("period_kept_clear", period_out, 32'd100);
        do_step(1'b1, 5, 1'b0, 1'b0, 32'd100);
        for (int i = 0; i < 2; i++) do_step(1'b1, 92, 1'b0, 1'b1, 32'd100);
        for (int i = 0; i < 5; i++) do_step(1'b0, 92, 1'b0, 1'b1, 32'd100);
        chk("pos_minus2", pos_out, 32'hFFFF_FFFE);

        // From 0 one reverse -> 0xFFFFFFFF, then back to 0
        pulse_clear();
        do_step(1'b0, 5, 1'b0, 1'b0, 32'd100);
        chk("pos_minus1", pos_out, 32'hFFFF_FFFF);
        do_step(1'b1, 92, 1'b0, 1'b1, 32'd100);

        // Steps every 200 cycles, then silence until stall
        for (int i = 0; i < 3; i++) do_step(1'b1, 192, 1'b0, 1'b1, 32'd200);
        repeat (998) @(negedge clk);
        chk("not_stalled_999", stalled, 1'b0);
        @(negedge clk);
        chk("stalled_1000", stalled, 1'b1);
        chk("period_kept_stall", period_out, 32'd200);
        repeat (20) @(negedge clk);
        chk("stalled_holds", stalled, 1'b1);
        do_step(1'b1, 0, 1'b0, 1'b0, 32'd200);
        do_step(1'b1, 192, 1'b0, 1'b1, 32'd200);
        chk("pos_after_stall", pos_out, 32'd5);

        // Clear coinciding with a detected edge drops the step
        do_step(1'b1, 20, 1'b1, 1'b0, 32'd200);
        do_step(1'b1, 0, 1'b0, 1'b0, 32'd200);

        // Count up to 42 with 8-cycle spacing (small instance wraps 7 -> 8)
        for (int i = 0; i < 41; i++) do_step(1'b1, 0, 1'b0, 1'b1, 32'd8);
        chk("pos_42", pos_out, 32'd42);
        chk("pos_small_42", pos_small, 4'hA);

        // Asynchronous reset mid-MEASURE
        @(negedge clk);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("arst_pos", pos_out, 32'h0);
        chk("arst_pos_small", pos_small, 4'h0);
        chk("arst_pulse", step_pulse, 1'b0);
        chk("arst_period", period_out, 32'h0);
        chk("arst_pv", period_valid, 1'b0);
        chk("arst_stalled", stalled, 1'b0);
        @(negedge clk);
        reset_reset_n = 1'b1;
        exp_pos       = 32'h0;
        do_step(1'b1, 3, 1'b0, 1'b0, 32'd0);
        chk("pos_after_arst", pos_out, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
